// File: rtl/simon_seq_ctrl.sv
// Simon game sequencer: grows per-player colour sequences from a Galois LFSR,
// plays them back one-hot, checks button presses and keeps both scores.
module simon_seq_ctrl #(
  parameter int          MAX_LEN        = 16,
  parameter int          SHOW_CYCLES    = 4,
  parameter int          GAP_CYCLES     = 2,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        two_player,
  input  logic        in_valid,
  input  logic [3:0]  in_color,
  output logic [3:0]  outcolor,
  output logic        ready,
  output logic        correct,
  output logic [7:0]  score_p1,
  output logic [7:0]  score_p2,
  output logic [31:0] seq_p1,
  output logic [31:0] seq_p2,
  output logic [4:0]  len_p1,
  output logic [4:0]  len_p2,
  output logic        active_p2,
  output logic        game_over,
  output logic        winner_p2
);

  typedef enum logic [2:0] {
    S_IDLE, S_EXTEND, S_SHOW, S_GAP, S_WAIT_IN, S_OVER
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] seq_p1_q, seq_p1_d, seq_p2_q, seq_p2_d;
  logic [4:0]  len_p1_q, len_p1_d, len_p2_q, len_p2_d;
  logic [7:0]  score_p1_q, score_p1_d, score_p2_q, score_p2_d;
  logic        active_p2_q, active_p2_d;
  logic        winner_p2_q, winner_p2_d;
  logic        mode_q, mode_d;
  logic        correct_q, correct_d;
  logic [4:0]  pos_q, pos_d;
  logic [15:0] cnt_q, cnt_d;

  logic [31:0] act_seq;
  logic [4:0]  act_len, oth_len;
  logic [1:0]  cur_code;
  logic [3:0]  cur_onehot;
  logic        press_ok, last_pos;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    act_seq    = active_p2_q ? seq_p2_q : seq_p1_q;
    act_len    = active_p2_q ? len_p2_q : len_p1_q;
    oth_len    = active_p2_q ? len_p1_q : len_p2_q;
    cur_code   = 2'(act_seq >> {pos_q, 1'b0});
    cur_onehot = 4'b0001 << cur_code;
    press_ok   = $onehot(in_color) && (in_color == cur_onehot);
    last_pos   = (pos_q + 5'd1) == act_len;
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    seq_p1_d    = seq_p1_q;
    seq_p2_d    = seq_p2_q;
    len_p1_d    = len_p1_q;
    len_p2_d    = len_p2_q;
    score_p1_d  = score_p1_q;
    score_p2_d  = score_p2_q;
    active_p2_d = active_p2_q;
    winner_p2_d = winner_p2_q;
    mode_d      = mode_q;
    correct_d   = 1'b0;
    pos_d       = pos_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          seq_p1_d    = '0;
          seq_p2_d    = '0;
          len_p1_d    = '0;
          len_p2_d    = '0;
          score_p1_d  = '0;
          score_p2_d  = '0;
          active_p2_d = 1'b0;
          winner_p2_d = 1'b0;
          mode_d      = two_player;
          pos_d       = '0;
          cnt_d       = '0;
          state_d     = S_EXTEND;
        end
      end
      S_EXTEND: begin
        // The new code lands in a slot that is still zero, so OR-ing is enough.
        if (active_p2_q) begin
          seq_p2_d = seq_p2_q | (32'(lfsr_q[1:0]) << {len_p2_q, 1'b0});
          len_p2_d = len_p2_q + 5'd1;
        end else begin
          seq_p1_d = seq_p1_q | (32'(lfsr_q[1:0]) << {len_p1_q, 1'b0});
          len_p1_d = len_p1_q + 5'd1;
        end
        pos_d   = '0;
        cnt_d   = '0;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (cnt_q == 16'(SHOW_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 16'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (last_pos) begin
            pos_d   = '0;
            state_d = S_WAIT_IN;
          end else begin
            pos_d   = pos_q + 5'd1;
            state_d = S_SHOW;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT_IN: begin
        if (in_valid && !press_ok) begin
          winner_p2_d = mode_q & ~active_p2_q;
          state_d     = S_OVER;
        end else if (in_valid && last_pos) begin
          correct_d = 1'b1;
          pos_d     = '0;
          cnt_d     = '0;
          if (active_p2_q) score_p2_d = sat_inc(score_p2_q);
          else             score_p1_d = sat_inc(score_p1_q);
          if (act_len == 5'(MAX_LEN)) begin
            winner_p2_d = active_p2_q;
            state_d     = S_OVER;
          end else begin
            // A player whose sequence is full sits out; the other keeps playing.
            if (mode_q && (oth_len < 5'(MAX_LEN))) active_p2_d = ~active_p2_q;
            state_d = S_EXTEND;
          end
        end else if (in_valid) begin
          pos_d = pos_q + 5'd1;
          cnt_d = '0;
        end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          winner_p2_d = mode_q & ~active_p2_q;
          state_d     = S_OVER;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      seq_p1_q    <= '0;
      seq_p2_q    <= '0;
      len_p1_q    <= '0;
      len_p2_q    <= '0;
      score_p1_q  <= '0;
      score_p2_q  <= '0;
      active_p2_q <= 1'b0;
      winner_p2_q <= 1'b0;
      mode_q      <= 1'b0;
      correct_q   <= 1'b0;
      pos_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      seq_p1_q    <= seq_p1_d;
      seq_p2_q    <= seq_p2_d;
      len_p1_q    <= len_p1_d;
      len_p2_q    <= len_p2_d;
      score_p1_q  <= score_p1_d;
      score_p2_q  <= score_p2_d;
      active_p2_q <= active_p2_d;
      winner_p2_q <= winner_p2_d;
      mode_q      <= mode_d;
      correct_q   <= correct_d;
      pos_q       <= pos_d;
      cnt_q       <= cnt_d;
    end
  end

  assign outcolor  = (state_q == S_SHOW) ? cur_onehot : 4'b0000;
  assign ready     = (state_q == S_WAIT_IN);
  assign game_over = (state_q == S_OVER);
  assign correct   = correct_q;
  assign score_p1  = score_p1_q;
  assign score_p2  = score_p2_q;
  assign seq_p1    = seq_p1_q;
  assign seq_p2    = seq_p2_q;
  assign len_p1    = len_p1_q;
  assign len_p2    = len_p2_q;
  assign active_p2 = active_p2_q;
  assign winner_p2 = winner_p2_q;

endmodule

// File: doc/simon_seq_ctrl.md
# simon_seq_ctrl

Game sequencer for the Simon (Genius) design. It generates each player's colour sequence and plays it out as one-hot colour on the display side. It then checks the player's button presses against the stored sequence and maintains both players' scores. It is the producer that drives the shared control bundle, while the input handler supplies the button presses.

## Interface
Parameters:
- MAX_LEN, 16: maximum sequence length. Each colour is a 2-bit code, so 16 codes fit the 32-bit sequence registers.
- SHOW_CYCLES, 4: cycles each colour is displayed.
- GAP_CYCLES, 2: blank cycles between displayed colours.
- TIMEOUT_CYCLES, 64: idle cycles allowed in WAIT_IN before the player loses.
- LFSR_SEED, 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- clk  in  1  system clock. Single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  start or restart pulse. Accepted only in IDLE or OVER.
- two_player  in  1  mode select, sampled when start is accepted.
- in_valid  in  1  one-cycle strobe: in_color holds a button press.
- in_color  in  4  one-hot press: bit0 Green, bit1 Yellow, bit2 Red, bit3 Blue.
- outcolor  out  4  one-hot colour being displayed, or 0.
- ready  out  1  high in WAIT_IN, meaning input is accepted.
- correct  out  1  one-cycle pulse when a round completes correctly.
- score_p1, score_p2  out  8  rounds completed per player. Saturate at 255.
- seq_p1, seq_p2  out  32  per-player sequence. Code k occupies bits [2k+1:2k].
- len_p1, len_p2  out  5  current sequence lengths, 0..MAX_LEN.
- active_p2  out  1  0 = player 1 active, 1 = player 2 active.
- game_over  out  1  high in OVER.
- winner_p2  out  1  valid while game_over is high.

## Operation
- Reset: all outputs are 0, the state is IDLE, and the LFSR is set to LFSR_SEED.
- LFSR:
  - 16-bit Galois LFSR with mask 16'hB400.
  - Advances every cycle out of reset.
  - The new colour code is lfsr[1:0], sampled in EXTEND.
- States:
  - IDLE: on start, clear seq_*, len_*, score_*, active_p2 and winner_p2; latch the mode; go to EXTEND.
  - EXTEND:
    - Append the code at index len of the active player; increment that len.
    - Clear pos; go to SHOW.
  - SHOW:
    - outcolor = onehot(seq[pos]) for SHOW_CYCLES cycles, then go to GAP.
  - GAP:
    - outcolor = 0 for GAP_CYCLES cycles, then increment pos.
    - If pos equals len, clear pos and go to WAIT_IN. Otherwise go to SHOW.
  - WAIT_IN: ready = 1. On in_valid:
    - If in_color is not one-hot, or its encoding differs from seq[pos], the player loses.
    - If it matches, increment pos and restart the timeout counter.
    - If pos+1 equals len, the round is complete:
      - Pulse correct.
      - Increment the active player's score, saturating.
      - If len equals MAX_LEN, the active player wins and the state goes to OVER.
      - Otherwise, in two-player mode, toggle active_p2 if the other player's len < MAX_LEN; go to EXTEND.
  - Timeout: TIMEOUT_CYCLES consecutive WAIT_IN cycles without in_valid means the player loses.
  - Loss: go to OVER.
    - Two-player mode: winner_p2 = !active_p2.
    - Single-player mode: winner_p2 = 0.
  - OVER: game_over = 1, outcolor = 0, and scores and sequences are held. On start, do the same as IDLE.
- Ignored inputs:
  - in_valid outside WAIT_IN.
  - start outside IDLE and OVER.
  - If start and in_valid arrive in the same WAIT_IN cycle, the press is processed and start is ignored.
- Reset mid-game: an asynchronous return to the reset values, with no partial update.

## Timing
- start accepted at edge N: EXTEND in cycle N+1, first non-zero outcolor in cycle N+2.
- Playback of a length-L sequence takes L × (SHOW_CYCLES + GAP_CYCLES) cycles. ready rises the cycle after the last GAP cycle.
- Press to result:
  - correct and the score are registered on the edge that samples the final in_valid, so both are visible the next cycle.
  - ready drops in that same cycle.
- A mismatch registers game_over on the sampling edge.
- Back-to-back in_valid on consecutive cycles must all be evaluated.
- Timeout: game_over rises exactly TIMEOUT_CYCLES cycles after ready rises, or after the last accepted press.

## Test plan
- Single-player, perfect play for 3 rounds. The bench answers from seq_p1.
  - Required: len_p1 = 3, score_p1 = 3, three correct pulses.
  - Each playback shows exactly 4 colour cycles and 2 blank cycles per code.
- Wrong colour on press 2 of round 2.
  - Required: game_over = 1 the next cycle, winner_p2 = 0, score_p1 = 1.
- Two-player alternation.
  - Required: active_p2 toggles after each round; len_p1 and len_p2 grow independently.
  - A P2 loss gives winner_p2 = 0.
- Non-one-hot in_color = 4'b0011 in WAIT_IN gives a loss. in_valid during SHOW is ignored.
- Timeout: no press for 64 cycles after ready gives game_over. A press at cycle 63 gives no loss.
- MAX_LEN = 2 parameter build, single-player, perfect play.
  - Required: OVER after round 2 with winner_p2 = 0.
  - Assert rst_n mid-SHOW: all outputs go to 0 immediately.
